mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 13 +
 rtl/array_mult4.sv | 22 ++
 rtl/mult_arbiter.sv | 87 ++++++++
 tb/tb_mult_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
package mult_arb_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

endpackage

// File: rtl/array_mult4.sv
// 4x4 unsigned array multiplier: AND-gated partial-product rows summed in a ripple chain.
module array_mult4
  import mult_arb_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] p
);

  logic [PRODW-1:0] row [OPW];
  logic [PRODW-1:0] acc [OPW+1];

  assign acc[0] = '0;

  for (genvar i = 0; i < OPW; i++) begin : g_row
    assign row[i]   = {{(PRODW-OPW){1'b0}}, a & {OPW{b[i]}}} << i;
    assign acc[i+1] = acc[i] + row[i];
  end

  assign p = acc[OPW];

endmodule

// File: rtl/mult_arbiter.sv
// Two requesters share one combinational multiplier; a 3-state FSM accepts an
// operand pair, registers the product, then holds it until the consumer takes it.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PRODW-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  state_t           state;
  logic             last_grant;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic             op_id;
  logic [PRODW-1:0] product;
  logic             grant0;
  logic             grant1;

  // Requester 1 wins when alone, or in round-robin mode when requester 0 had the last grant.
  assign grant1 = req1_valid && (!req0_valid || ((RR_EN != 0) && !last_grant));
  assign grant0 = req0_valid && !grant1;

  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign res_valid  = (state == OUT);
  assign busy       = (state != IDLE);

  array_mult4 u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      done_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_a : req0_a;
            op_b       <= grant1 ? req1_b : req0_b;
            op_id      <= grant1;
            last_grant <= grant1;
            state      <= CALC;
          end
        end
        CALC: begin
          res_data <= product;
          res_id   <= op_id;
          state    <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            done_cnt <= done_cnt + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench: a round-robin instance for most scenarios and a
// fixed-priority instance for the priority scenario.
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_ready, res_id, busy;
  logic [7:0] res_data, done_cnt;

  logic       fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
  logic [3:0] fp_req0_a, fp_req0_b, fp_req1_a, fp_req1_b;
  logic       fp_res_valid, fp_res_ready, fp_res_id, fp_busy;
  logic [7:0] fp_res_data, fp_done_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.RR_EN(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  mult_arbiter #(.RR_EN(0)) u_dut_fp (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (fp_req0_valid),
    .req0_a     (fp_req0_a),
    .req0_b     (fp_req0_b),
    .req0_ready (fp_req0_ready),
    .req1_valid (fp_req1_valid),
    .req1_a     (fp_req1_a),
    .req1_b     (fp_req1_b),
    .req1_ready (fp_req1_ready),
    .res_valid  (fp_res_valid),
    .res_ready  (fp_res_ready),
    .res_data   (fp_res_data),
    .res_id     (fp_res_id),
    .busy       (fp_busy),
    .done_cnt   (fp_done_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                               input logic rr);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    res_ready  = rr;
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    fp_req0_valid = 1'b0; fp_req0_a = 4'd0; fp_req0_b = 4'd0;
    fp_req1_valid = 1'b0; fp_req1_a = 4'd0; fp_req1_b = 4'd0;
    fp_res_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitResult(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, " res_valid"}, res_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_res;
    int seen1;
    logic [3:0] a, b;
    logic [7:0] pair;

    // Reset state, with requests already presented
    resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b1, 4'd1, 4'd1, 1'b1);
    tick();
    checkOutput("rst req0_ready", req0_ready, 0);
    checkOutput("rst req1_ready", req1_ready, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst res_valid", res_valid, 0);
    checkOutput("rst res_data", res_data, 0);
    checkOutput("rst res_id", res_id, 0);
    checkOutput("rst done_cnt", done_cnt, 0);

    // 15 x 15 on requester 0
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("max req0_ready", req0_ready, 1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("max calc res_valid", res_valid, 0);
    checkOutput("max calc busy", busy, 1);
    checkOutput("max calc req0_ready", req0_ready, 0);
    tick();
    checkOutput("max out res_valid", res_valid, 1);
    checkOutput("max res_data", res_data, 225);
    checkOutput("max res_id", res_id, 0);
    checkOutput("max done before", done_cnt, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("max done after", done_cnt, 1);
    checkOutput("max idle res_valid", res_valid, 0);

    // Round robin: req0 first, then req1 even though req0 asks again
    resetDut();
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 4'd7, 4'd9, 1'b1);
    checkOutput("rr1 req0_ready", req0_ready, 1);
    checkOutput("rr1 req1_ready", req1_ready, 0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 4'd9, 1'b1);
    checkOutput("rr1 calc req1_ready", req1_ready, 0);
    tick();
    checkOutput("rr1 res_valid", res_valid, 1);
    checkOutput("rr1 res_data", res_data, 15);
    checkOutput("rr1 res_id", res_id, 0);
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b1, 4'd7, 4'd9, 1'b1);
    tick();
    checkOutput("rr2 req1_ready", req1_ready, 1);
    checkOutput("rr2 req0_ready", req0_ready, 0);
    checkOutput("rr2 idle res_valid", res_valid, 0);
    tick();
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkOutput("rr2 calc res_valid", res_valid, 0);
    tick();
    checkOutput("rr2 res_valid", res_valid, 1);
    checkOutput("rr2 res_data", res_data, 63);
    checkOutput("rr2 res_id", res_id, 1);
    tick();
    checkOutput("rr3 req0_ready", req0_ready, 1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("rr3 res_data", res_data, 1);
    checkOutput("rr3 res_id", res_id, 0);
    tick();
    checkOutput("rr done_cnt", done_cnt, 3);

    // Back-pressure in OUT with a pending request
    resetDut();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd3, 1'b0);
    checkOutput("bp req1_ready", req1_ready, 1);
    checkOutput("bp req0_ready", req0_ready, 0);
    tick();
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp res_valid", res_valid, 1);
      checkOutput("bp res_data", res_data, 6);
      checkOutput("bp res_id", res_id, 1);
      checkOutput("bp req0_ready", req0_ready, 0);
      checkOutput("bp req1_ready", req1_ready, 0);
      checkOutput("bp busy", busy, 1);
      tick();
    end
    checkOutput("bp done held", done_cnt, 0);
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("bp done", done_cnt, 1);
    checkOutput("bp idle res_valid", res_valid, 0);
    checkOutput("bp pending ready", req0_ready, 1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("bp pending res_data", res_data, 81);
    checkOutput("bp pending res_id", res_id, 0);
    tick();

    // Reset during CALC abandons the operation
    resetDut();
    applyStimulus(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 4'd0, 1'b1);
    checkOutput("ab req0_ready", req0_ready, 1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    checkOutput("ab calc busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("ab rst busy", busy, 0);
    checkOutput("ab rst res_valid", res_valid, 0);
    checkOutput("ab rst res_data", res_data, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ab res_valid", res_valid, 0);
      checkOutput("ab busy", busy, 0);
    end
    checkOutput("ab done_cnt", done_cnt, 0);
    applyStimulus(1'b1, 4'd5, 4'd6, 1'b0, 4'd0, 4'd0, 1'b1);
    checkOutput("ab next req0_ready", req0_ready, 1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    waitResult("ab next", 3);
    checkOutput("ab next res_data", res_data, 30);
    checkOutput("ab next res_id", res_id, 0);
    tick();
    checkOutput("ab next done_cnt", done_cnt, 1);

    // Fixed priority: req0 wins every time while both stay valid
    resetDut();
    fp_req0_valid = 1'b1; fp_req0_a = 4'd2; fp_req0_b = 4'd7;
    fp_req1_valid = 1'b1; fp_req1_a = 4'd3; fp_req1_b = 4'd3;
    fp_res_ready  = 1'b1;
    #1;
    checkOutput("fp req0_ready", fp_req0_ready, 1);
    checkOutput("fp req1_ready", fp_req1_ready, 0);
    n_res = 0;
    seen1 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fp_req1_ready) seen1 = 1;
      if (fp_res_valid) begin
        n_res++;
        checkOutput("fp res_id", fp_res_id, 0);
        checkOutput("fp res_data", fp_res_data, 14);
      end
    end
    checkOutput("fp results", n_res, 4);
    checkOutput("fp req1 granted", seen1, 0);
    checkOutput("fp done_cnt", fp_done_cnt, 4);

    // All 256 operand pairs, alternating requesters; done_cnt wraps to 0
    resetDut();
    for (int i = 0; i < 256; i++) begin
      pair = i[7:0];
      a = pair[7:4];
      b = pair[3:0];
      if (pair[0] == 1'b0) begin
        applyStimulus(1'b1, a, b, 1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("all req0_ready", req0_ready, 1);
      end else begin
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, a, b, 1'b1);
        checkOutput("all req1_ready", req1_ready, 1);
      end
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
      waitResult("all", 3);
      checkOutput("all res_data", res_data, int'(a) * int'(b));
      checkOutput("all res_id", res_id, pair[0]);
      tick();
      if (i == 254) checkOutput("all done 255", done_cnt, 255);
    end
    checkOutput("all done wrap", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
